icache_dm: RTL

- Parametrised direct-mapped, read-only instruction cache that replaces the single-cycle instruction pass-through between the datapath fetch port and the memory controller instruction port.
- Hits are returned combinationally in the request cycle.
- Misses run a multi-word block fill from memory.
- Provides whole-cache invalidate and hit/miss performance counters for the pipeline bring-up work.

---
 rtl/icache_dm.sv | 104 ++++++++++
 1 files changed

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache with zero-latency hits,
// multi-word block fill on miss, whole-cache invalidate and hit/miss counters.
module icache_dm #(
    parameter int SETS     = 16,
    parameter int BLKWORDS = 2,
    parameter int CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    input  logic             inv,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic [31:0]      iload,
    input  logic             iwait,
    output logic             busy,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int OFF_W = $clog2(BLKWORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int WC_W  = OFF_W > 0 ? OFF_W : 1;

    typedef enum logic {IDLE, FILL} state_t;
    state_t state, state_n;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      data [SETS][BLKWORDS];
    logic [29:0]      waddr;
    logic [TAG_W-1:0] tag, miss_tag;
    logic [IDX_W-1:0] idx, miss_idx;
    logic [WC_W-1:0]  off, wcnt;
    logic             pend, hit, miss, take, last;
    logic             unused_lsb;

    assign unused_lsb = ^imemaddr[1:0];
    assign waddr = imemaddr[31:2];
    assign off   = WC_W'(waddr & 30'(BLKWORDS - 1));
    assign idx   = IDX_W'(waddr >> OFF_W);
    assign tag   = TAG_W'(waddr >> (OFF_W + IDX_W));
    assign hit   = state == IDLE && imemREN && valid[idx] && tags[idx] == tag;
    assign miss  = state == IDLE && imemREN && !hit;
    assign take  = state == FILL && !iwait;
    assign last  = wcnt == WC_W'(BLKWORDS - 1);

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (state == IDLE) state_n = miss ? FILL : IDLE;
        else               state_n = take && last ? IDLE : FILL;
    end

    always_comb begin
        ihit     = hit;
        imemload = hit ? data[idx][off] : 32'h0;
        iREN     = state == FILL;
        busy     = state == FILL;
        iaddr    = state == FILL ? ((32'({miss_tag, miss_idx}) << OFF_W) | 32'(wcnt)) << 2 : 32'h0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid    <= '0;
            wcnt     <= '0;
            pend     <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit) hit_cnt <= hit_cnt + CNT_W'(1);
            if (miss) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
                wcnt     <= '0;
            end
            if (inv && state == FILL) pend <= 1'b1;
            if (inv) valid <= '0;
            // An invalidate seen at any point of the fill, even on the last word, leaves the line invalid
            if (take) begin
                wcnt <= last ? '0 : wcnt + WC_W'(1);
                if (last) begin
                    valid[miss_idx] <= !(pend || inv);
                    pend            <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (miss) begin
            miss_tag <= tag;
            miss_idx <= idx;
        end
        if (take) data[miss_idx][wcnt] <= iload;
        if (take && last) tags[miss_idx] <= miss_tag;
    end
endmodule
